// File: rtl/immediate_sign_extend.sv
// Decode-stage immediate extension: widens the instruction immediate to the
// datapath width in one of four modes, with a registered result and valid flag.
module immediate_sign_extend #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IMM_W-1:0] instr,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] extendImm,
    output logic             out_valid
);

    localparam int EXT_W = OUT_W - IMM_W;

    localparam logic [1:0] MODE_SEXT      = 2'b00;
    localparam logic [1:0] MODE_ZEXT      = 2'b01;
    localparam logic [1:0] MODE_SEXT_SHL2 = 2'b10;
    localparam logic [1:0] MODE_UPPER     = 2'b11;

    logic             sign;
    logic [OUT_W-1:0] imm_sext;
    logic [OUT_W-1:0] imm_zext;
    logic [OUT_W-1:0] imm_shl2;
    logic [OUT_W-1:0] imm_upper;
    logic [OUT_W-1:0] imm_next;

    assign sign      = instr[IMM_W-1];
    assign imm_sext  = {{EXT_W{sign}}, instr};
    assign imm_zext  = {{EXT_W{1'b0}}, instr};
    // Word-offset scaling: the two MSBs of the sign-extended value fall off.
    assign imm_shl2  = {imm_sext[OUT_W-3:0], 2'b00};
    assign imm_upper = {instr, {EXT_W{1'b0}}};

    always_comb begin
        imm_next = imm_sext;
        unique case (mode)
            MODE_SEXT:      imm_next = imm_sext;
            MODE_ZEXT:      imm_next = imm_zext;
            MODE_SEXT_SHL2: imm_next = imm_shl2;
            MODE_UPPER:     imm_next = imm_upper;
            default:        imm_next = imm_sext;
        endcase
    end

    // mode/instr only reach the flops when in_valid is high, so idle X on them is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            extendImm <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            extendImm <= imm_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_immediate_sign_extend.sv
// Scoreboard bench for immediate_sign_extend: expected values are queued as
// stimulus is applied and popped when the registered result appears.
module tb_immediate_sign_extend;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] extendImm;
    logic        out_valid;

    int vectors;
    int miscompares;
    logic [31:0] sb[$];
    logic [31:0] last_exp;

    immediate_sign_extend #(.IMM_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mode      (mode),
        .in_valid  (in_valid),
        .extendImm (extendImm),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed arithmetically rather than by bit concatenation.
    function automatic logic [31:0] model(input logic [15:0] i, input logic [1:0] m);
        logic [31:0] s;
        s = (i >= 16'h8000) ? (32'(i) - 32'h0001_0000) : 32'(i);
        case (m)
            2'b00:   model = s;
            2'b01:   model = 32'(i);
            2'b10:   model = s * 32'd4;
            default: model = 32'(i) << 16;
        endcase
    endfunction

    // Apply one cycle of stimulus; queue the expected result if it will be captured.
    task automatic cycle(input logic r, input logic v, input logic [15:0] i, input logic [1:0] m);
        rst      = r;
        in_valid = v;
        instr    = i;
        mode     = m;
        if (!r && v) sb.push_back(model(i, m));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, 16'h8001, 2'b00);
            vectors++;
            if (extendImm !== 32'h0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got imm=%h vld=%b, want imm=00000000 vld=0", k, extendImm, out_valid);
            end
        end
        cycle(1'b0, 1'b1, 16'h8001, 2'b00);
        vectors++;
        if (sb.size() == 0 || out_valid !== 1'b1 || extendImm !== sb[0]) begin
            miscompares++;
            $display("FAIL reset_release: got imm=%h vld=%b, want imm=FFFF8001 vld=1", extendImm, out_valid);
        end
        if (sb.size() != 0) last_exp = sb.pop_front();
    endtask

    task automatic test_modes();
        logic [15:0] ti[9] = '{16'h0000, 16'h0001, 16'h8001, 16'h8001, 16'h7FFF,
                               16'hFFFF, 16'h8001, 16'h0003, 16'h8001};
        logic [1:0]  tm[9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
        logic [31:0] tx[9] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_8001, 32'h0000_8001,
                               32'h0000_7FFF, 32'hFFFF_FFFF, 32'hFFFE_0004, 32'h0000_000C,
                               32'h8001_0000};
        logic [31:0] exp;
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 1'b1, ti[k], tm[k]);
            exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            vectors++;
            if (extendImm !== exp || extendImm !== tx[k] || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL mode[%0d] instr=%h mode=%b: got imm=%h vld=%b, want imm=%h vld=1",
                         k, ti[k], tm[k], extendImm, out_valid, tx[k]);
            end
            last_exp = tx[k];
        end
        for (int m = 0; m < 4; m++) begin
            cycle(1'b0, 1'b1, 16'h0000, 2'(m));
            exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            vectors++;
            if (extendImm !== 32'h0 || exp !== 32'h0) begin
                miscompares++;
                $display("FAIL zero_mode%0d: got imm=%h, want 00000000", m, extendImm);
            end
            last_exp = 32'h0;
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, 16'h8001, 2'b00);
        if (sb.size() != 0) last_exp = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 16'h1234, 2'(k + 1));
            vectors++;
            if (extendImm !== 32'hFFFF_8001 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: got imm=%h vld=%b, want imm=FFFF8001 vld=0", k, extendImm, out_valid);
            end
        end
    endtask

    task automatic test_midstream_reset();
        cycle(1'b0, 1'b1, 16'h1111, 2'b01);
        if (sb.size() != 0) last_exp = sb.pop_front();
        cycle(1'b1, 1'b1, 16'h2222, 2'b11);
        vectors++;
        if (extendImm !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_rst: got imm=%h vld=%b, want imm=00000000 vld=0", extendImm, out_valid);
        end
        cycle(1'b0, 1'b1, 16'hC000, 2'b10);
        vectors++;
        if (sb.size() == 0 || extendImm !== 32'hFFFF_0000 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midstream_resume: got imm=%h vld=%b, want imm=FFFF0000 vld=1", extendImm, out_valid);
        end
        if (sb.size() != 0) last_exp = sb.pop_front();
    endtask

    task automatic test_back_to_back();
        logic        v;
        logic [15:0] i;
        logic [1:0]  m;
        logic [31:0] exp;
        for (int k = 0; k < 60; k++) begin
            v = ($urandom_range(0, 3) != 0);
            i = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            cycle(1'b0, v, i, m);
            if (v) exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            else   exp = last_exp;
            vectors++;
            if (extendImm !== exp || out_valid !== v) begin
                miscompares++;
                $display("FAIL b2b[%0d] v=%b instr=%h mode=%b: got imm=%h vld=%b, want imm=%h vld=%b",
                         k, v, i, m, extendImm, out_valid, exp, v);
            end
            last_exp = exp;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_exp    = '0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        instr       = '0;
        mode        = '0;
        @(negedge clk);
        test_reset();
        test_modes();
        test_hold();
        test_midstream_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
